// File: rtl/bank_register.sv
// Scalar register file: R0..R14 stored, R15 reads return the externally supplied PC+8.
// Two combinational read ports and one synchronous write port, with no write-to-read bypass.
module bank_register #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WE3,
  input  logic [3:0]       A1,
  input  logic [3:0]       A2,
  input  logic [3:0]       A3,
  input  logic [WIDTH-1:0] WD3,
  input  logic [WIDTH-1:0] r15,
  output logic [WIDTH-1:0] RD1,
  output logic [WIDTH-1:0] RD2
);

  localparam int unsigned NumRegs = 15;

  logic [WIDTH-1:0] regs_q [NumRegs];

  // Each register has its own address decode, so A3=15 matches none and is dropped.
  for (genvar i = 0; i < NumRegs; i++) begin : g_regs
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        regs_q[i] <= '0;
      end else if (WE3 && (A3 == 4'(i))) begin
        regs_q[i] <= WD3;
      end
    end
  end

  always_comb begin
    RD1 = r15;
    RD2 = r15;
    for (int i = 0; i < NumRegs; i++) begin
      if (A1 == 4'(i)) RD1 = regs_q[i];
      if (A2 == 4'(i)) RD2 = regs_q[i];
    end
  end

endmodule

// File: tb/tb_bank_register.sv
// Self-checking bench for bank_register: directed scenarios plus randomized traffic
// compared against an array-based reference model of the architectural registers.
`timescale 1ns/100ps
module tb_bank_register;

  localparam int unsigned WIDTH = 32;

  logic             CLK;
  logic             RST;
  logic             WE3;
  logic [3:0]       A1;
  logic [3:0]       A2;
  logic [3:0]       A3;
  logic [WIDTH-1:0] WD3;
  logic [WIDTH-1:0] r15;
  logic [WIDTH-1:0] RD1;
  logic [WIDTH-1:0] RD2;

  int checks;
  int errors;

  logic [WIDTH-1:0] model [15];

  bank_register #(.WIDTH(WIDTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .WE3 (WE3),
    .A1  (A1),
    .A2  (A2),
    .A3  (A3),
    .WD3 (WD3),
    .r15 (r15),
    .RD1 (RD1),
    .RD2 (RD2)
  );

  initial CLK = 1'b0;
  always #20 CLK = ~CLK;

  function automatic logic [WIDTH-1:0] expect_rd(input logic [3:0] a);
    if (a == 4'd15) return r15;
    return model[a];
  endfunction

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reads(input string tag);
    check({tag, "_rd1"}, RD1, expect_rd(A1));
    check({tag, "_rd2"}, RD2, expect_rd(A2));
  endtask

  task automatic clear_model();
    for (int i = 0; i < 15; i++) model[i] = '0;
  endtask

  // Advance one rising edge, apply the architectural write rule, then settle.
  task automatic tick();
    @(posedge CLK);
    if (RST && WE3 && A3 != 4'd15) model[A3] = WD3;
    #1;
  endtask

  // Read every address through both ports; WE3 is held low so edges crossed are harmless.
  task automatic check_all(input string tag);
    logic we_save;
    we_save = WE3;
    WE3 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      A1 = 4'(2 * i);
      A2 = 4'(2 * i + 1);
      #1;
      check_reads(tag);
    end
    WE3 = we_save;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_model();
    RST = 1'b0;
    WE3 = 1'b0;
    A1  = 4'd1;
    A2  = 4'd4;
    A3  = 4'd0;
    WD3 = '0;
    r15 = 32'hAAAA_AAAA;

    // Reset state
    #1;
    check("rst_a1", RD1, 32'h0);
    check("rst_a2", RD2, 32'h0);
    A1 = 4'd15;
    #1;
    check("rst_r15", RD1, 32'hAAAA_AAAA);
    // Writes blocked while in reset
    WE3 = 1'b1; A3 = 4'd3; WD3 = 32'h1111_2222; A1 = 4'd3;
    tick();
    check("rst_block", RD1, 32'h0);
    WE3 = 1'b0;
    RST = 1'b1;

    // Randomized traffic: reads before and after each edge
    for (int n = 0; n < 60; n++) begin
      WE3 = 1'($urandom_range(0, 3) != 0);
      A3  = 4'($urandom_range(0, 15));
      WD3 = $urandom;
      A1  = ($urandom_range(0, 3) == 0) ? A3 : 4'($urandom_range(0, 15));
      A2  = 4'($urandom_range(0, 15));
      r15 = $urandom;
      #1;
      check_reads("rand_pre");
      tick();
      check_reads("rand_post");
    end
    check_all("rand_sweep");

    // 1. Asynchronous reset pulse between edges
    @(negedge CLK);
    A1 = 4'd1; A2 = 4'd4; WE3 = 1'b0;
    RST = 1'b0;
    clear_model();
    #1;
    check("t1_a1", RD1, 32'h0);
    check("t1_a2", RD2, 32'h0);
    A1 = 4'd15; r15 = 32'hAAAA_AAAA;
    #1;
    check("t1_r15", RD1, 32'hAAAA_AAAA);
    RST = 1'b1;
    check_all("t1_sweep");

    // 2. Write enable gating
    A3 = 4'd8; WD3 = 32'hFFFC_0007; WE3 = 1'b0; A1 = 4'd8;
    tick();
    check("t2_we0", RD1, 32'h0);
    WE3 = 1'b1;
    tick();
    check("t2_we1", RD1, 32'hFFFC_0007);

    // 3. Port 1 timing: old value until the edge, no bypass
    WE3 = 1'b1; A3 = 4'd1; WD3 = 32'hF000_0007; A1 = 4'd1;
    #1;
    check("t3_pre", RD1, 32'h0);
    tick();
    check("t3_post", RD1, 32'hF000_0007);
    WE3 = 1'b0; WD3 = 32'h0BAD_0BAD;
    tick();
    check("t3_hold", RD1, 32'hF000_0007);

    // 4. Port 2
    WE3 = 1'b1; A3 = 4'd4; WD3 = 32'hF00F_F007; A2 = 4'd4;
    tick();
    tick();
    check("t4_rd2", RD2, 32'hF00F_F007);
    check("t4_rd1", RD1, 32'hF000_0007);
    WE3 = 1'b0;

    // 5. R15 handling
    A1 = 4'd15; A2 = 4'd15;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: r15 = 32'hAAAA_AAAA;
        1: r15 = 32'hAAA9_55AA;
        2: r15 = 32'h0000_2AAA;
        default: r15 = 32'hAAAA_FFFF;
      endcase
      #1;
      check("t5_rd1", RD1, r15);
      check("t5_rd2", RD2, RD1);
    end
    WE3 = 1'b1; A3 = 4'd15; WD3 = 32'h1234_5678;
    tick();
    check("t5_wr15", RD1, 32'hAAAA_FFFF);
    check_all("t5_sweep");

    // 6. Reset coincident with an edge overrides the pending write
    WE3 = 1'b1; A3 = 4'd2; WD3 = 32'hDEAD_BEEF; A1 = 4'd2;
    @(negedge CLK);
    @(posedge CLK);
    RST = 1'b0;
    clear_model();
    #1;
    check("t6_rst", RD1, 32'h0);
    RST = 1'b1;
    tick();
    check("t6_after", RD1, 32'hDEAD_BEEF);
    check_all("t6_sweep");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bank_register.md
Name: bank_register

Overview:
- ARM-style scalar register file: 16 architectural registers R0..R15 of WIDTH bits, two combinational read ports (A1/RD1, A2/RD2) and one synchronous write port (A3/WD3/WE3).
- R0..R14 are storage; R15 is not stored. Reads of address 15 return the externally supplied r15 value, which is PC+8 from the fetch stage.
- Sits in the datapath between decode and execute.

Parameters:
- WIDTH, 32, bit width of every register, WD3, r15, RD1 and RD2.

Ports:
- CLK  input  1  system clock; all writes occur on its rising edge.
- RST  input  1  asynchronous, active-low reset (0 = reset asserted).
- WE3  input  1  write enable for the write port.
- A1  input  4  read address, port 1.
- A2  input  4  read address, port 2.
- A3  input  4  write address.
- WD3  input  WIDTH  write data.
- r15  input  WIDTH  value returned for reads of address 15 (PC+8).
- RD1  output  WIDTH  read data, port 1.
- RD2  output  WIDTH  read data, port 2.

Behaviour:
- Storage: 15 registers, R0..R14, each WIDTH bits.
- Reset:
  - RST=0 immediately clears R0..R14 to 0, independent of CLK.
  - While RST=0, writes are blocked.
  - While RST=0, RD1/RD2 read 0 for addresses 0..14 and r15 for address 15.
  - Reset asserted mid-operation overrides any pending write in the same cycle.
  - Deassertion is asynchronous. The first write can take effect on the first rising CLK edge with RST=1.
- Write:
  - On the rising CLK edge with RST=1, WE3=1 and A3 in 0..14: R[A3] <= WD3.
  - WE3=0: no register changes.
  - A3=15 with WE3=1: write is silently discarded. R15 is never stored; PC update is the PC logic's job.
- Read:
  - Purely combinational, zero latency.
  - RDn = r15 when An=15, otherwise R[An].
  - r15 changes propagate to RD1/RD2 combinationally with no clock needed.
- Read-during-write to the same address in the same cycle:
  - No bypass. RD shows the old value until the active edge, then the new value.
- Both read ports are independent. A1=A2 is legal, and both ports return the same value.
- No X propagation from unwritten registers, because reset defines all of them.
- No other state. No wrap-around or overflow conditions exist; all 4-bit address values are legal.

Test Plan:
1. Reset: pulse RST=0 between clock edges with arbitrary data in registers. Required: RD1/RD2 = 0 for A1=1, A2=4 immediately, without a clock edge. A1=15 with r15=0xAAAAAAAA gives RD1=0xAAAAAAAA.
2. Write enable gating: A3=8, WD3=0xFFFC0007, WE3=0, then a clock edge. Required: R8 unchanged (0).
   - Then set WE3=1 and apply an edge. Required: reading A1=8 returns 0xFFFC0007.
3. Write/read port 1 timing: WE3=1, A3=1, WD3=0xF0000007, A1=1.
   - Required: RD1 stays at its old value before the edge and becomes 0xF0000007 right after the rising edge.
   - Then drop WE3=0, change WD3, and clock. Required: RD1 holds 0xF0000007.
4. Port 2: WE3=1, A3=4, WD3=0xF00FF007, A2=4, then two clock edges. Required: RD2=0xF00FF007. RD1 (A1=1) still reads 0xF0000007.
5. R15 handling: A1=A2=15.
   - Sweep r15 through 0xAAAAAAAA, 0xAAA955AA, 0x00002AAA, 0xAAAAFFFF. Required: RD1=RD2=r15 combinationally.
   - Write WE3=1, A3=15, WD3=0x12345678. Required: the write has no effect, RD still equals r15, and R0..R14 are unchanged.
6. Reset mid-operation: assert RST=0 coincident with a rising edge while WE3=1, A3=2, WD3=0xDEADBEEF.
   - Required: R2=0 after the edge.
   - Then deassert RST and apply one edge. Required: R2=0xDEADBEEF.
